// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RV32I control path: opcodes, FSM states, ALU and mux encodings.
// Latency: none (declarations only).
// Backpressure: none.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

  // Operation class handed from the FSM to the ALU decoder.
  typedef enum logic [1:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_R, ALU_OP_I
  } alu_op_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADDR_PC      = 1'b0;
  localparam logic ADDR_ALUOUT  = 1'b1;
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/riscv_alu_decode.sv
// Maps the FSM's operation class plus funct3/funct7_5 onto the ALU control code.
// Latency: combinational.
// Backpressure: none.
module riscv_alu_decode
  import riscv_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  // funct7_5 selects SUB only for register ops; for immediates it only distinguishes SRAI.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALU_OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: drives datapath selects/enables, owns the shared memory port, counts retirements.
// Latency: 3-5 cycles per instruction with zero-wait memory.
// Backpressure: FETCH/MEM_RD/MEM_WR hold with stable request and address select until mem_ready.
module riscv_mc_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic        trap,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  alu_op_e     alu_op;

  riscv_alu_decode u_alu_decode (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (alu_ctrl)
  );

  // State and retirement counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, control decode and retirement count; reset forces every strobe low.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = ADDR_PC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_OP_ADD;
    result_src = RES_ALUOUT;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/JAL target is precomputed here into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_WB_ALU;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_OP_R;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_I;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_src = ADDR_ALUOUT;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = ADDR_ALUOUT;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_OP_SUB;
        pc_write  = br_cond;
        pc_src    = PCSRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Link value oldPC+4 comes straight off the ALU; target sits in ALUOut.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        pc_src    = PCSRC_ALU;
        state_d   = S_WB_ALU;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + 32'd1;

    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      trap      = 1'b0;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Randomized and directed bench for riscv_mc_ctrl against a per-instruction behavioural model.
// Latency: n/a.
// Backpressure: bench memory inserts programmable mem_ready wait cycles.
module tb_riscv_mc_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        br_cond;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  riscv_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .br_cond(br_cond), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .result_src(result_src), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int zero_wait_cycles(logic [6:0] op);
    case (op)
      OP_R, OP_I:        return 4;
      OP_LUI:            return 3;
      OP_LOAD:           return 5;
      OP_STORE:          return 4;
      OP_BRANCH, OP_JAL: return 3;
      OP_JALR:           return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit is_mem(logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic bit writes_rd(logic [6:0] op);
    return (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

  function automatic logic [1:0] wb_source(logic [6:0] op);
    if (op == OP_LOAD) return RES_MEM;
    if (op == OP_JAL || op == OP_LUI) return RES_ALU;
    return RES_ALUOUT;
  endfunction

  // RV32I mnemonic lookup: funct3 names the operation; bit 30 picks SUB (reg only) or arithmetic shift.
  function automatic logic [3:0] alu_for(bit is_reg, logic [2:0] f3, logic f75);
    logic [3:0] base [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (f3 == 3'd0 && is_reg && f75) return ALU_SUB;
    if (f3 == 3'd5 && f75) return ALU_SRA;
    return base[f3];
  endfunction

  function automatic logic [6:0] op_of(int k);
    case (k)
      0: return OP_R;      1: return OP_I;    2: return OP_LOAD;  3: return OP_STORE;
      4: return OP_BRANCH; 5: return OP_JAL;  6: return OP_JALR;  default: return OP_LUI;
    endcase
  endfunction

  // ---------------- stimulus / observation ----------------
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic brc, input int fw, input int mw,
                           output int cyc, output int rw_cnt, output int rw_cyc,
                           output logic [1:0] rw_res, output int pcw_cnt, output logic pcsrc_last,
                           output int mreq_cnt, output int mwe_cnt, output int maddr_cnt,
                           output int irw_cnt, output logic [3:0] ex_alu, output bit timeout);
    logic [31:0] start;
    int wl;
    bit ex_seen;
    opcode = op; funct3 = f3; funct7_5 = f75; br_cond = brc;
    start = instret; wl = fw; ex_seen = 0; timeout = 1;
    cyc = 0; rw_cnt = 0; rw_cyc = 0; rw_res = 2'b11; pcw_cnt = 0; pcsrc_last = 1'bx;
    mreq_cnt = 0; mwe_cnt = 0; maddr_cnt = 0; irw_cnt = 0; ex_alu = 4'hF;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (wl > 0) begin mem_ready = 1'b0; wl--; end
        else begin mem_ready = 1'b1; wl = mw; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (reg_write) begin rw_cnt++; rw_cyc = c + 1; rw_res = result_src; end
      if (pc_write) begin pcw_cnt++; pcsrc_last = pc_src; end
      if (mem_req) mreq_cnt++;
      if (mem_req && mem_we) mwe_cnt++;
      if (mem_req && addr_src) maddr_cnt++;
      if (ir_write) irw_cnt++;
      if (!ex_seen && alu_src_a == SRCA_RS1) begin ex_alu = alu_ctrl; ex_seen = 1; end
      @(posedge clk); #1;
      if (instret != start) begin cyc = c + 1; timeout = 0; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; br_cond = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if ({ir_write, pc_write, reg_write, mem_we, trap} !== 5'b0) begin bad++;
      $display("FAIL reset_enables got=%b exp=00000", {ir_write, pc_write, reg_write, mem_we, trap}); end
    total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({mem_req, addr_src, mem_we} !== 3'b100) begin bad++;
      $display("FAIL reset_fetch got=%b exp=100", {mem_req, addr_src, mem_we}); end
    exp_ret = 0;
  endtask

  task automatic test_addi();
    int cyc, rwn, rwc, pcw, mrq, mwe, mad, irw; logic [1:0] rs; logic ps; logic [3:0] ea; bit to;
    run_instr(OP_I, 3'd0, 1'b0, 1'b0, 0, 0, cyc, rwn, rwc, rs, pcw, ps, mrq, mwe, mad, irw, ea, to);
    exp_ret++;
    total++; if (to || cyc !== 4) begin bad++; $display("FAIL addi_cycles got=%0d exp=4", cyc); end
    total++; if (rwn !== 1 || rwc !== 4) begin bad++; $display("FAIL addi_regwrite cnt=%0d cyc=%0d exp=1/4", rwn, rwc); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL addi_instret got=%0d exp=1", instret); end
    total++; if (ea !== ALU_ADD) begin bad++; $display("FAIL addi_alu got=%0d exp=%0d", ea, ALU_ADD); end
  endtask

  task automatic test_lw_wait();
    int cyc, rwn, rwc, pcw, mrq, mwe, mad, irw; logic [1:0] rs; logic ps; logic [3:0] ea; bit to;
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 2, cyc, rwn, rwc, rs, pcw, ps, mrq, mwe, mad, irw, ea, to);
    exp_ret++;
    total++; if (to || cyc !== 7) begin bad++; $display("FAIL lw_cycles got=%0d exp=7", cyc); end
    total++; if (mad !== 3 || mrq !== 4 || mwe !== 0) begin bad++;
      $display("FAIL lw_memport addr1=%0d req=%0d we=%0d exp=3/4/0", mad, mrq, mwe); end
    total++; if (rwn !== 1 || rs !== RES_MEM) begin bad++; $display("FAIL lw_wb cnt=%0d res=%b exp=1/01", rwn, rs); end
    total++; if (instret !== 32'(exp_ret)) begin bad++; $display("FAIL lw_instret got=%0d exp=%0d", instret, exp_ret); end
  endtask

  task automatic test_branch();
    int cyc, rwn, rwc, pcw, mrq, mwe, mad, irw; logic [1:0] rs; logic ps; logic [3:0] ea; bit to;
    for (int t = 0; t < 2; t++) begin
      run_instr(OP_BRANCH, 3'd0, 1'b0, (t == 0), 0, 0, cyc, rwn, rwc, rs, pcw, ps, mrq, mwe, mad, irw, ea, to);
      exp_ret++;
      total++; if (to || cyc !== 3) begin bad++; $display("FAIL beq%0d_cycles got=%0d exp=3", t, cyc); end
      total++; if (pcw !== ((t == 0) ? 2 : 1)) begin bad++;
        $display("FAIL beq%0d_pcwrite got=%0d exp=%0d", t, pcw, (t == 0) ? 2 : 1); end
      total++; if (rwn !== 0) begin bad++; $display("FAIL beq%0d_regwrite got=%0d exp=0", t, rwn); end
    end
  endtask

  task automatic test_alu_codes();
    int cyc, rwn, rwc, pcw, mrq, mwe, mad, irw; logic [1:0] rs; logic ps; logic [3:0] ea; bit to;
    logic [6:0] ops [5]; logic f75s [5]; logic [2:0] f3s [5]; logic [3:0] exps [5];
    ops  = '{OP_I,    OP_I,    OP_R,    OP_R,    OP_I};
    f3s  = '{3'd5,    3'd5,    3'd0,    3'd0,    3'd0};
    f75s = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
    exps = '{ALU_SRA, ALU_SRL, ALU_SUB, ALU_ADD, ALU_ADD};
    for (int i = 0; i < 5; i++) begin
      run_instr(ops[i], f3s[i], f75s[i], 1'b0, 0, 0, cyc, rwn, rwc, rs, pcw, ps, mrq, mwe, mad, irw, ea, to);
      exp_ret++;
      total++; if (to || ea !== exps[i]) begin bad++; $display("FAIL alu_code%0d got=%0d exp=%0d", i, ea, exps[i]); end
    end
  endtask

  task automatic test_random();
    int cyc, rwn, rwc, pcw, mrq, mwe, mad, irw; logic [1:0] rs; logic ps; logic [3:0] ea; bit to;
    logic [6:0] op; logic [2:0] f3; logic f75, brc; int fw, mw;
    int e_cyc, e_pcw, e_mem; logic e_ps;
    for (int n = 0; n < 40; n++) begin
      op = op_of($urandom_range(0, 7)); f3 = 3'($urandom_range(0, 7)); f75 = 1'($urandom_range(0, 1));
      brc = 1'($urandom_range(0, 1)); fw = $urandom_range(0, 2); mw = $urandom_range(0, 2);
      run_instr(op, f3, f75, brc, fw, mw, cyc, rwn, rwc, rs, pcw, ps, mrq, mwe, mad, irw, ea, to);
      exp_ret++;
      e_mem = is_mem(op) ? 1 + mw : 0;
      e_cyc = zero_wait_cycles(op) + fw + (is_mem(op) ? mw : 0);
      e_pcw = 1 + ((op == OP_JAL || op == OP_JALR) ? 1 : (op == OP_BRANCH) ? int'(brc) : 0);
      e_ps  = (op == OP_JAL) || (op == OP_BRANCH && brc);
      total++; if (to || cyc !== e_cyc) begin bad++; $display("FAIL rnd%0d_cycles op=%b got=%0d exp=%0d", n, op, cyc, e_cyc); end
      total++; if (instret !== 32'(exp_ret)) begin bad++; $display("FAIL rnd%0d_instret got=%0d exp=%0d", n, instret, exp_ret); end
      total++; if (rwn !== (writes_rd(op) ? 1 : 0)) begin bad++; $display("FAIL rnd%0d_regwrite op=%b got=%0d", n, op, rwn); end
      if (writes_rd(op)) begin
        total++; if (rs !== wb_source(op) || rwc !== cyc) begin bad++;
          $display("FAIL rnd%0d_wb op=%b res=%b cyc=%0d exp=%b/%0d", n, op, rs, rwc, wb_source(op), cyc); end
      end
      total++; if (pcw !== e_pcw || ps !== e_ps) begin bad++;
        $display("FAIL rnd%0d_pc op=%b cnt=%0d src=%b exp=%0d/%b", n, op, pcw, ps, e_pcw, e_ps); end
      total++; if (mrq !== 1 + fw + e_mem || mad !== e_mem || mwe !== ((op == OP_STORE) ? e_mem : 0)) begin bad++;
        $display("FAIL rnd%0d_mem op=%b req=%0d a1=%0d we=%0d", n, op, mrq, mad, mwe); end
      total++; if (irw !== 1) begin bad++; $display("FAIL rnd%0d_irwrite got=%0d exp=1", n, irw); end
      if (op == OP_R || op == OP_I) begin
        total++; if (ea !== alu_for(op == OP_R, f3, f75)) begin bad++;
          $display("FAIL rnd%0d_alu op=%b f3=%0d f75=%b got=%0d exp=%0d", n, op, f3, f75, ea, alu_for(op == OP_R, f3, f75)); end
      end
    end
  endtask

  task automatic test_trap();
    opcode = 7'b0000000; mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL trap_flag got=%b exp=1", trap); end
    total++; if ({mem_req, ir_write, pc_write, reg_write, mem_we} !== 5'b0) begin bad++;
      $display("FAIL trap_enables got=%b exp=00000", {mem_req, ir_write, pc_write, reg_write, mem_we}); end
    total++; if (instret !== 32'(exp_ret)) begin bad++; $display("FAIL trap_instret got=%0d exp=%0d", instret, exp_ret); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (trap !== 1'b0 || instret !== 32'd0) begin bad++;
      $display("FAIL trap_reset trap=%b instret=%0d exp=0/0", trap, instret); end
    reset = 1'b0; mem_ready = 1'b0; exp_ret = 0;
    #1;
    total++; if ({mem_req, addr_src} !== 2'b10) begin bad++; $display("FAIL trap_refetch got=%b exp=10", {mem_req, addr_src}); end
  endtask

  task automatic test_reset_mem_wr();
    bit found = 0;
    opcode = OP_STORE; funct3 = 3'd2;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin found = 1; mem_ready = 1'b0; end
      else mem_ready = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rstwr_reach got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || instret !== 32'd0) begin bad++;
      $display("FAIL rstwr_drop mem_req=%b instret=%0d exp=0/0", mem_req, instret); end
    reset = 1'b0;
    #1;
    total++; if ({mem_req, addr_src, mem_we} !== 3'b100) begin bad++;
      $display("FAIL rstwr_fetch got=%b exp=100", {mem_req, addr_src, mem_we}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_alu_codes();
    test_random();
    test_trap();
    test_reset_mem_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
